// File: rtl/spi_pkg.sv
// Shared types and constants for the burst SPI slave memory endpoint.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RD_TA,
    ST_RDATA
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Bit counter must hold values up to the longer of the address and data fields.
  function automatic int unsigned cnt_width(input int unsigned aw, input int unsigned dw);
    return $clog2(((aw > dw) ? aw : dw) + 1);
  endfunction

endpackage

// File: rtl/spi_ram_sync.sv
// Single-port memory with write enable and one-cycle registered read.
module spi_ram_sync #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_slave_burst_mem.sv
// SPI slave with command decode, address pointers and auto-incrementing burst access to local memory.
module spi_slave_burst_mem
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter bit          BURST_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_err
);

  localparam int unsigned CNT_W = cnt_width(ADDR_W, DATA_W);
  localparam int unsigned SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic              armed_q, armed_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SH_W-1:0]   shift_q, shift_d, shift_in;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              miso_q, miso_d, busy_q, busy_d, frame_err_q, frame_err_d;
  logic              ram_we_c, ram_re_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_wdata_c, ram_rdata;

  spi_ram_sync #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .re    (ram_re_c),
    .addr  (ram_addr_c),
    .wdata (ram_wdata_c),
    .rdata (ram_rdata)
  );

  // Next-state, datapath and output decode
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | SS_n;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    shift_in    = {shift_q[SH_W-2:0], MOSI};
    shift_d     = shift_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_d       = out_q;
    miso_d      = 1'b0;
    frame_err_d = 1'b0;
    ram_we_c    = 1'b0;
    ram_re_c    = 1'b0;
    ram_addr_c  = rd_ptr_q;
    ram_wdata_c = shift_in[DATA_W-1:0];

    if (state_q != ST_IDLE && SS_n) begin
      // Frame ended: drop any partial word, flag only mid-field aborts
      state_d = ST_IDLE;
      cnt_d   = '0;
      unique case (state_q)
        ST_CMD:   frame_err_d = 1'b1;
        ST_ADDR:  frame_err_d = (cnt_q != '0) && (cnt_q <= CNT_ADDR_LAST);
        ST_WDATA: frame_err_d = (cnt_q != '0);
        default:  frame_err_d = 1'b0;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!SS_n && armed_q) begin
            shift_d = shift_in;
            state_d = ST_CMD;
          end
        end
        ST_CMD: begin
          cmd_d = {shift_q[0], MOSI};
          cnt_d = '0;
          unique case (cmd_d)
            CMD_WR_ADDR, CMD_RD_ADDR: state_d = ST_ADDR;
            CMD_WR_DATA:              state_d = ST_WDATA;
            default:                  state_d = ST_RD_TA;
          endcase
        end
        ST_ADDR: begin
          if (cnt_q <= CNT_ADDR_LAST) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_ADDR_LAST) begin
              if (cmd_q == CMD_WR_ADDR) wr_ptr_d = shift_in[ADDR_W-1:0];
              else                      rd_ptr_d = shift_in[ADDR_W-1:0];
            end
          end
        end
        ST_WDATA: begin
          shift_d = shift_in;
          if (cnt_q == CNT_DATA_LAST) begin
            ram_we_c   = 1'b1;
            ram_addr_c = wr_ptr_q;
            cnt_d      = '0;
            if (BURST_EN) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RD_TA: begin
          // Turnaround and inter-word gap: fetch the word at rd_ptr
          ram_re_c = 1'b1;
          cnt_d    = '0;
          state_d  = ST_RDATA;
        end
        ST_RDATA: begin
          if (cnt_q == '0) begin
            miso_d = ram_rdata[DATA_W-1];
            out_d  = ram_rdata << 1;
          end else begin
            miso_d = out_q[DATA_W-1];
            out_d  = out_q << 1;
          end
          if (cnt_q == CNT_DATA_LAST) begin
            cnt_d   = '0;
            state_d = ST_RD_TA;
            if (BURST_EN) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      cmd_q       <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_q       <= '0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_q       <= out_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign MISO      = miso_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_burst_mem.sv
// Directed bench for spi_slave_burst_mem: a burst instance and a non-burst instance on one clock.
module tb_spi_slave_burst_mem;

  logic clk, rst, ss_n, mosi, sel;
  logic ss_n_a, ss_n_b, miso_a, miso_b, busy_a, busy_b, ferr_a, ferr_b;
  logic miso, busy, ferr;
  int   tests = 0;
  int   fails = 0;

  assign ss_n_a = sel ? 1'b1 : ss_n;
  assign ss_n_b = sel ? ss_n : 1'b1;
  assign miso   = sel ? miso_b : miso_a;
  assign busy   = sel ? busy_b : busy_a;
  assign ferr   = sel ? ferr_b : ferr_a;

  spi_slave_burst_mem #(.ADDR_W(8), .DATA_W(8), .BURST_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .SS_n(ss_n_a), .MOSI(mosi),
    .MISO(miso_a), .busy(busy_a), .frame_err(ferr_a)
  );

  spi_slave_burst_mem #(.ADDR_W(8), .DATA_W(8), .BURST_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .SS_n(ss_n_b), .MOSI(mosi),
    .MISO(miso_b), .busy(busy_b), .frame_err(ferr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ss_n = 1'b0;
    mosi = b;
    step();
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic end_frame(input string tag, input logic exp_err);
    ss_n = 1'b1;
    mosi = 1'b0;
    step();
    check({tag, "_ferr"}, 32'(ferr), 32'(exp_err));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_miso"}, 32'(miso), 32'd0);
  endtask

  task automatic set_ptr(input logic [1:0] c, input logic [7:0] a, input string tag);
    send_bits(16'(c), 2);
    send_bits(16'(a), 8);
    end_frame(tag, 1'b0);
  endtask

  task automatic wr_data(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                         input int n, input string tag);
    logic [7:0] w [3];
    w = '{w0, w1, w2};
    send_bits(16'b01, 2);
    for (int k = 0; k < n; k++) send_bits(16'(w[k]), 8);
    end_frame(tag, 1'b0);
  endtask

  task automatic rd_data(input int n, input logic [7:0] e0, input logic [7:0] e1, input string tag);
    logic [7:0] e [2];
    logic [7:0] word;
    e = '{e0, e1};
    send_bits(16'b11, 2);
    send_bit(1'b1);
    check({tag, "_ta"}, 32'(miso), 32'd0);
    for (int k = 0; k < n; k++) begin
      for (int b = 7; b >= 0; b--) begin
        send_bit(1'b1);
        word[b] = miso;
      end
      check($sformatf("%s_w%0d", tag, k), 32'(word), 32'(e[k]));
      if (k < n - 1) begin
        send_bit(1'b1);
        check($sformatf("%s_gap%0d", tag, k), 32'(miso), 32'd0);
      end
    end
    end_frame(tag, 1'b0);
  endtask

  initial begin
    rst  = 1'b1;
    ss_n = 1'b0;
    mosi = 1'b0;
    sel  = 1'b0;

    // 1: reset with SS_n low, then arm requirement
    for (int i = 0; i < 4; i++) begin
      mosi = 1'($urandom);
      step();
      check($sformatf("rst_outs%0d", i), {29'd0, miso, busy, ferr}, 32'd0);
    end
    rst = 1'b0;
    send_bit(1'b1);
    check("unarmed_busy0", 32'(busy), 32'd0);
    send_bit(1'b0);
    check("unarmed_busy1", 32'(busy), 32'd0);
    ss_n = 1'b1;
    step();
    send_bit(1'b0);
    check("armed_e0_busy", 32'(busy), 32'd1);
    end_frame("cmd_abort", 1'b1);
    step();
    check("cmd_abort_pulse", 32'(ferr), 32'd0);

    // 2: basic burst
    set_ptr(2'b00, 8'h10, "t2_wa");
    wr_data(8'hA5, 8'h3C, 8'h00, 2, "t2_wd");
    set_ptr(2'b10, 8'h10, "t2_ra");
    rd_data(2, 8'hA5, 8'h3C, "t2_rd");

    // 3: pointer wrap
    set_ptr(2'b00, 8'hFF, "t3_wa");
    wr_data(8'h11, 8'h22, 8'h00, 2, "t3_wd");
    set_ptr(2'b10, 8'hFF, "t3_ra");
    rd_data(2, 8'h11, 8'h22, "t3_rd");

    // 4: partial write word
    set_ptr(2'b00, 8'h41, "t4_wa0");
    wr_data(8'h5A, 8'h00, 8'h00, 1, "t4_wd0");
    set_ptr(2'b00, 8'h40, "t4_wa1");
    send_bits(16'b01, 2);
    send_bits(16'h77, 8);
    send_bits(16'b10110, 5);
    end_frame("t4_abort", 1'b1);
    step();
    check("t4_pulse_end", 32'(ferr), 32'd0);
    set_ptr(2'b10, 8'h40, "t4_ra");
    rd_data(2, 8'h77, 8'h5A, "t4_rd");

    // 4b: partial address aborts with an error
    send_bits(16'b00, 2);
    send_bits(16'b101, 3);
    end_frame("addr_abort", 1'b1);

    // 5: non-burst instance
    sel = 1'b1;
    set_ptr(2'b00, 8'h21, "t5_wa0");
    wr_data(8'hEE, 8'h00, 8'h00, 1, "t5_wd0");
    set_ptr(2'b00, 8'h20, "t5_wa1");
    wr_data(8'h01, 8'h02, 8'h03, 3, "t5_wd1");
    set_ptr(2'b10, 8'h20, "t5_ra0");
    rd_data(2, 8'h03, 8'h03, "t5_rd0");
    set_ptr(2'b10, 8'h21, "t5_ra1");
    rd_data(1, 8'hEE, 8'h00, "t5_rd1");
    sel = 1'b0;

    // 6: reset during the 4th RDATA bit of a read from 0x10 (0xA5)
    set_ptr(2'b10, 8'h10, "t6_ra");
    send_bits(16'b11, 2);
    send_bit(1'b0);
    send_bits(16'h0, 3);
    check("t6_bit3", 32'(miso), 32'd1);
    rst = 1'b1;
    send_bit(1'b0);
    check("t6_rst_miso", 32'(miso), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    send_bit(1'b1);
    check("t6_unarmed", 32'(busy), 32'd0);
    ss_n = 1'b1;
    step();
    rd_data(1, 8'h22, 8'h00, "t6_rd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
